// File: rtl/vga_capture.sv
// vga_capture: receive side of the VGA path. Registers the incoming 3-bit RGB stream
// and its active-low syncs on the pixel clock, measures line and frame lengths against
// the expected timing and, once two consecutive clean frames have been seen, writes a
// 256x240 subsampled frame into a 64K x 3 frame buffer. The write address uses the
// same {y[8:1], x[7:0]} layout the display side reads, so a captured frame replays as is.
//
// Ports
//   clk          pixel clock, all logic on the rising edge
//   reset_n      asynchronous active-low reset
//   h_sync       horizontal sync, active low
//   v_sync       vertical sync, active low
//   rgb[2:0]     pixel data
//   wr_en        frame-buffer write strobe, one cycle per written pixel
//   wr_addr[15:0] write address {y[8:1], x[7:0]}
//   wr_data[2:0] captured pixel
//   locked       timing verified, capture active
//   frame_start  one-cycle pulse per captured frame
//   sync_err     one-cycle pulse when lock is lost

module vga_capture #(
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [2:0]  rgb,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [2:0]  wr_data,
  output logic        locked,
  output logic        frame_start,
  output logic        sync_err
);

  localparam logic [9:0]  HTot   = 10'(H_TOTAL);
  localparam logic [10:0] HTotW  = 11'(H_TOTAL);
  localparam logic [9:0]  VTot   = 10'(V_TOTAL);
  localparam logic [10:0] VTotW  = 11'(V_TOTAL);
  localparam logic [9:0]  XOff   = 10'(H_SYNC + H_BACK);
  localparam logic [9:0]  YOff   = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  YAct   = 10'(V_ACTIVE);
  localparam logic [9:0]  CntMax = 10'd1023;

  typedef enum logic [1:0] {
    StSearch,
    StMeasure,
    StLocked
  } state_e;

  // Input stage and previous-value registers for edge detection
  logic       h_sync_r, v_sync_r;
  logic       h_sync_p, v_sync_p;
  logic [2:0] rgb_r;

  // Position counters
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;

  // Control state
  state_e state_q;
  logic   hseen_q;

  // Decoded per-cycle conditions
  logic       hfall, vfall;
  logic       line_bad, frame_bad;
  logic [9:0] x, y;
  logic       in_window;

  // Sync registers reset low so the first post-reset sample can only look like a
  // rising edge, never a spurious falling one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_sync_r <= 1'b0;
      v_sync_r <= 1'b0;
      h_sync_p <= 1'b0;
      v_sync_p <= 1'b0;
      rgb_r    <= 3'd0;
    end else begin
      h_sync_r <= h_sync;
      v_sync_r <= v_sync;
      h_sync_p <= h_sync_r;
      v_sync_p <= v_sync_r;
      rgb_r    <= rgb;
    end
  end

  always_comb begin
    hfall = h_sync_p & ~h_sync_r;
    vfall = v_sync_p & ~v_sync_r;
  end

  // h_cnt reads 0 the cycle after hfall, so a correct line shows h_cnt == H_TOTAL-1
  // on the next hfall. Both counters saturate so a dead input cannot wrap into a
  // plausible count.
  always_comb begin
    h_cnt_d = h_cnt_q;
    if (hfall) begin
      h_cnt_d = 10'd0;
    end else if (h_cnt_q != CntMax) begin
      h_cnt_d = h_cnt_q + 10'd1;
    end

    v_cnt_d = v_cnt_q;
    if (vfall) begin
      v_cnt_d = 10'd0;
    end else if (hfall && (v_cnt_q != CntMax)) begin
      v_cnt_d = v_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q <= 10'd0;
      v_cnt_q <= 10'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Length checks are done in 11 bits so a saturated counter plus one cannot alias.
  always_comb begin
    line_bad  = (hfall && hseen_q && (({1'b0, h_cnt_q} + 11'd1) != HTotW)) ||
                (h_cnt_q == HTot);
    frame_bad = (vfall && (({1'b0, v_cnt_q} + 11'd1) != VTotW)) ||
                (v_cnt_q == VTot);
  end

  // Unsigned wrap puts blanking positions far above the active limits.
  always_comb begin
    x         = h_cnt_q - XOff;
    y         = v_cnt_q - YOff;
    in_window = (x < 10'd256) && (y < YAct) && !y[0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StSearch;
      hseen_q     <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= 16'd0;
      wr_data     <= 3'd0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      wr_en       <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;

      if (hfall) begin
        hseen_q <= 1'b1;
      end

      case (state_q)
        StSearch: begin
          if (vfall && hseen_q) begin
            state_q <= StMeasure;
          end
        end

        StMeasure: begin
          if (line_bad) begin
            state_q <= StSearch;
            hseen_q <= 1'b0;
          end else if (vfall && !frame_bad) begin
            state_q     <= StLocked;
            locked      <= 1'b1;
            frame_start <= 1'b1;
          end
          // vfall with a bad frame length: stay here, the counters have already
          // restarted the measurement.
        end

        StLocked: begin
          if (line_bad || frame_bad) begin
            state_q  <= StSearch;
            hseen_q  <= 1'b0;
            locked   <= 1'b0;
            sync_err <= 1'b1;
          end else begin
            if (vfall) begin
              frame_start <= 1'b1;
            end
            if (in_window) begin
              wr_en   <= 1'b1;
              wr_addr <= {y[8:1], x[7:0]};
              wr_data <= rgb_r;
            end
          end
        end

        default: begin
          state_q <= StSearch;
          hseen_q <= 1'b0;
          locked  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture. Uses a reduced raster (300 x 10 with a 256-pixel window and
// three captured lines) so several full frames fit in a short run; the x = 256 column
// and the odd-line skipping still occur inside every frame.
`timescale 1ns/1ps
module tb_vga_capture;

  localparam int HT = 300;
  localparam int HS = 16;
  localparam int HB = 16;
  localparam int VT = 10;
  localparam int VS = 1;
  localparam int VB = 2;
  localparam int VA = 6;
  localparam int FrameCyc   = HT * VT;
  localparam int XStart     = HS + HB + 1;  // pin column that lands at x = 0
  localparam int WrPerFrame = 256 * (VA / 2);
  localparam int LastAddr   = (((VA - 2) / 2) << 8) | 255;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        h_sync = 1'b1;
  logic        v_sync = 1'b1;
  logic [2:0]  rgb = 3'd0;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [2:0]  wr_data;
  logic        locked;
  logic        frame_start;
  logic        sync_err;
  logic [22:0] outs;

  assign outs = {wr_en, wr_addr, wr_data, locked, frame_start, sync_err};

  vga_capture #(
    .H_TOTAL (HT),
    .H_SYNC  (HS),
    .H_BACK  (HB),
    .V_TOTAL (VT),
    .V_SYNC  (VS),
    .V_BACK  (VB),
    .V_ACTIVE(VA)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .rgb        (rgb),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .locked     (locked),
    .frame_start(frame_start),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Raster generator, driven on the falling edge. Requests from the main sequence are
  // counters so each variable has a single writer.
  bit gen_run = 1'b0;
  int start_line = 5;
  int short_line_req = 0, short_line_done = 0;
  int short_frame_req = 0, short_frame_done = 0;
  int skip_vs_req = 0, skip_vs_done = 0;
  int gcol = 0, gline = 0, cur_hlen = HT, cur_lines = VT;
  bit skip_vs_cur = 1'b0;
  int vf_cnt = 0, vf_edge = 0, skip_edge = 0;

  initial forever begin
    @(negedge clk);
    if (!gen_run) begin
      h_sync = 1'b1;
      v_sync = 1'b1;
      rgb    = 3'd0;
      gcol   = 0;
      gline  = start_line;
    end else begin
      if (gcol == 0) begin
        cur_hlen = HT;
        if (short_line_req != short_line_done) begin
          cur_hlen = HT - 1;
          short_line_done = short_line_req;
        end
        if (gline == 0) begin
          cur_lines = VT;
          if (short_frame_req != short_frame_done) begin
            cur_lines = VT - 1;
            short_frame_done = short_frame_req;
          end
          skip_vs_cur = 1'b0;
          if (skip_vs_req != skip_vs_done) begin
            skip_vs_cur  = 1'b1;
            skip_vs_done = skip_vs_req;
            skip_edge    = cyc + 1;
          end else begin
            vf_cnt++;
            vf_edge = cyc + 1;
          end
        end
      end
      h_sync = (gcol >= HS);
      v_sync = (gline >= VS) || skip_vs_cur;
      rgb    = 3'(gcol - XStart);
      gcol++;
      if (gcol == cur_hlen) begin
        gcol  = 0;
        gline = (gline + 1 == cur_lines) ? 0 : gline + 1;
      end
    end
  end

  // Output monitor: writes inside a frame must run 0, 1, 2, ... with data = x[2:0].
  int  wr_total = 0, wr_bad = 0, seq = 0, frame_wr = -1;
  int  first_addr = -1, first_data = -1, last_addr = -1, last_data = -1;
  int  serr_total = 0, fs_cyc = 0, lock_cyc = 0;
  bit  locked_prev = 1'b0;

  initial forever begin
    @(negedge clk);
    if (frame_start) begin
      fs_cyc   = cyc;
      frame_wr = seq;
      seq      = 0;
    end
    if (sync_err) serr_total++;
    if (locked && !locked_prev) lock_cyc = cyc;
    locked_prev = locked;
    if (wr_en) begin
      wr_total++;
      if (seq == 0) begin
        first_addr = int'(wr_addr);
        first_data = int'(wr_data);
      end
      if (int'(wr_addr) != seq || wr_data != wr_addr[2:0]) wr_bad++;
      last_addr = int'(wr_addr);
      last_data = int'(wr_data);
      seq++;
    end
  end

  task automatic wait_vf(input int n);
    int target;
    int k;
    target = vf_cnt + n;
    k = 0;
    while (vf_cnt < target && k < (n + 1) * FrameCyc) begin
      @(negedge clk);
      k++;
    end
    check("vfall_reached", int'(vf_cnt >= target), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_serr(input string tag);
    int k;
    k = 0;
    while (!sync_err && k < 3 * FrameCyc) begin
      @(negedge clk);
      k++;
    end
    check(tag, int'(sync_err), 1);
  endtask

  int serr0, wr0, k6;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outs", int'(outs), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_outs", int'(outs), 0);

    // Clean timing from reset
    gen_run = 1'b1;
    wait_vf(1);
    check("s1_measure_unlocked", int'(locked), 0);
    wait_vf(1);
    check("s1_locked", int'(locked), 1);
    check("s1_lock_cycle", lock_cyc, vf_edge + 1);
    check("s1_fs_with_lock", fs_cyc, lock_cyc);
    check("s1_no_serr", serr_total, 0);

    // One full locked frame with rgb = x[2:0]
    wait_vf(1);
    check("s2_frame_writes", frame_wr, WrPerFrame);
    check("s2_first_addr", first_addr, 0);
    check("s2_first_data", first_data, 0);
    check("s2_last_addr", last_addr, LastAddr);
    check("s2_last_data", last_data, 7);
    check("s2_seq_errors", wr_bad, 0);
    check("s2_fs_cycle", fs_cyc, vf_edge + 1);
    check("s2_still_locked", int'(locked), 1);

    // One 299-clock line while locked
    serr0 = serr_total;
    short_line_req++;
    wait_serr("s3_serr_seen");
    check("s3_locked_low", int'(locked), 0);
    check("s3_no_wr_at_err", int'(wr_en), 0);
    wr0 = wr_total;
    wait_vf(1);
    check("s3_measure_unlocked", int'(locked), 0);
    wait_vf(1);
    check("s3_relocked", int'(locked), 1);
    check("s3_zero_writes", wr_total - wr0, 0);
    check("s3_one_serr", serr_total - serr0, 1);

    // Suppressed vsync while locked
    skip_vs_req++;
    wait_serr("s4_serr_seen");
    check("s4_err_cycle", cyc, skip_edge + 2);
    check("s4_locked_low", int'(locked), 0);

    // Short frame during measurement
    reset_n = 1'b0;
    gen_run = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    short_frame_req++;
    serr0 = serr_total;
    repeat (2) @(negedge clk);
    gen_run = 1'b1;
    wait_vf(1);
    check("s5_measure_unlocked", int'(locked), 0);
    wait_vf(1);
    check("s5_short_frame_unlocked", int'(locked), 0);
    check("s5_no_serr", serr_total - serr0, 0);
    wait_vf(1);
    check("s5_locked", int'(locked), 1);
    check("s5_lock_cycle", lock_cyc, vf_edge + 1);

    // Reset in the middle of a written line
    k6 = 0;
    while (!(wr_en && wr_addr == 16'h0105) && k6 < 2 * FrameCyc) begin
      @(negedge clk);
      k6++;
    end
    check("s6_writing", int'(wr_data), 5);
    reset_n = 1'b0;
    #1;
    check("s6_async_clear", int'(outs), 0);
    k6 = 0;
    while (gline != 2 && k6 < 2 * FrameCyc) begin
      @(negedge clk);
      k6++;
    end
    check("s6_held_clear", int'(outs), 0);
    reset_n = 1'b1;
    serr0 = serr_total;
    wait_vf(1);
    check("s6_measure_unlocked", int'(locked), 0);
    wait_vf(1);
    check("s6_relocked", int'(locked), 1);
    check("s6_lock_cycle", lock_cyc, vf_edge + 1);
    check("s6_fs_with_lock", fs_cyc, lock_cyc);
    check("s6_no_serr", serr_total - serr0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/vga_capture.md
# vga_capture

Receive-side counterpart of the VGA controller/ROM path. Samples an incoming 3-bit RGB VGA stream with its hsync/vsync on the pixel clock and checks the sync timing. Once locked, writes a 256x240 subsampled frame into a 64K x 3 frame buffer. The write address uses the same `{y[8:1], x[7:0]}` layout the display side reads, so a captured frame can be replayed unchanged.

## Interface
- H_TOTAL, 800, clocks per line
- H_SYNC, 96, hsync pulse width in clocks
- H_BACK, 48, back porch in clocks
- V_TOTAL, 525, lines per frame
- V_SYNC, 2, vsync width in lines
- V_BACK, 33, back porch in lines
- V_ACTIVE, 480, active lines
- clk  in  1  pixel clock; all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- h_sync  in  1  horizontal sync, active low
- v_sync  in  1  vertical sync, active low
- rgb  in  3  pixel data
- wr_en  out  1  frame-buffer write strobe
- wr_addr  out  16  write address `{y[8:1], x[7:0]}`
- wr_data  out  3  captured pixel
- locked  out  1  timing verified, capture active
- frame_start  out  1  one-cycle pulse per captured frame
- sync_err  out  1  one-cycle pulse on loss of lock

## Operation
- Input stage: h_sync, v_sync and rgb are registered once (`*_r`). A previous-value register gives falling-edge detects `hfall` and `vfall`.
- h_cnt (10 bits):
  - cleared to 0 on the `hfall` cycle;
  - otherwise increments and saturates at 1023.
- v_cnt (10 bits):
  - cleared to 0 on the `vfall` cycle; `vfall` wins over a coincident `hfall`;
  - otherwise increments on each `hfall` and saturates at 1023.
- `hseen` flag: set by the first `hfall` after reset or after entry to SEARCH.
- `line_bad` asserts on either condition:
  - `hfall` with `hseen` set and h_cnt+1 != H_TOTAL;
  - h_cnt == H_TOTAL (missing hsync).
- `frame_bad` asserts on either condition:
  - `vfall` with v_cnt+1 != V_TOTAL;
  - v_cnt == V_TOTAL (missing vsync).
- States:
  - SEARCH: `vfall` with `hseen` set -> MEASURE.
  - MEASURE: `line_bad` -> SEARCH. `vfall` with `frame_bad` -> stay in MEASURE, restart the measurement. `vfall` without `frame_bad` -> LOCKED.
  - LOCKED: `line_bad` or `frame_bad` -> SEARCH and pulse sync_err.
- Position: x = h_cnt − (H_SYNC+H_BACK), y = v_cnt − (V_SYNC+V_BACK), using unsigned wrap.
- Write qualifier, all of the following true:
  - state LOCKED, with no `line_bad`/`frame_bad` this cycle;
  - x < 256;
  - y < V_ACTIVE;
  - y[0] == 0.
- Each qualified write: wr_addr = `{y[8:1], x[7:0]}`, wr_data = `rgb_r`.
- Writes per frame = 256 × 240 = 61440.

## Timing
- Reset: all outputs 0, state SEARCH, counters 0, `hseen` 0.
- Pixel latency: pin sample at cycle n -> `rgb_r` at n+1 -> wr_en/wr_addr/wr_data valid at n+2. All outputs are registered.
- wr_en is high for exactly one cycle per written pixel; wr_addr and wr_data are don't-care while wr_en = 0.
- locked rises the cycle after the `vfall` that enters LOCKED.
- frame_start pulses on the same cycle locked rises, then on every subsequent `vfall` that keeps LOCKED.
- On an error in LOCKED:
  - sync_err = 1 and locked = 0 on the cycle after detection;
  - no wr_en is produced from the detecting cycle onward.
- Relock needs a fresh SEARCH -> MEASURE -> LOCKED sequence, i.e. at least two `vfall` events after `hseen`.
- MEASURE failures never pulse sync_err.
- reset_n low mid-frame: outputs clear immediately (asynchronously). On release, restart in SEARCH.

## Test plan
- Clean 800x525 timing from reset:
  - locked = 1 one cycle after the 2nd `vfall` following the 1st `hfall`;
  - frame_start pulses on that cycle;
  - sync_err never pulses.
- Locked frame with rgb = x[2:0]:
  - exactly 61440 wr_en pulses per frame;
  - first write wr_addr = 0x0000, wr_data = 0;
  - last write wr_addr = 0xEFFF (y = 478, x = 255), wr_data = 7;
  - no write for x = 256 or for odd y.
- Inject one 799-clock line while locked:
  - sync_err pulses once and locked falls;
  - zero writes until relock two frames later.
- Suppress one vsync while locked: error when v_cnt reaches 525; sync_err = 1, locked = 0.
- 524-line frame during MEASURE: locked stays 0, no sync_err; the next correct 525-line frame locks.
- Assert reset_n mid-line while locked: all outputs 0 within the reset assertion; after release, behaviour matches scenario 1.
